// File: rtl/n_bit_alu_seq_if.sv
// Operand/result bundle between the issue stage, the sequential ALU and writeback.
// Latency: none (wires only); timing is set by the ALU that owns the slave side.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Ports: in_valid, in_ready, A, B, control (request); out_valid, out_ready,
//        ALU_Result, zero, carry, overflow, negative (result).
interface n_bit_alu_seq_if #(
    parameter int n = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [n-1:0] A;
    logic [n-1:0] B;
    logic [3:0]   control;
    logic         out_valid;
    logic         out_ready;
    logic [n-1:0] ALU_Result;
    logic         zero;
    logic         carry;
    logic         overflow;
    logic         negative;

    // Upstream issue stage / downstream writeback view.
    modport master (
        output in_valid, A, B, control, out_ready,
        input  in_ready, out_valid, ALU_Result, zero, carry, overflow, negative
    );

    // ALU view.
    modport slave (
        input  in_valid, A, B, control, out_ready,
        output in_ready, out_valid, ALU_Result, zero, carry, overflow, negative
    );
endinterface

// File: rtl/n_bit_alu_seq.sv
// Sequential n-bit ALU: one operation at a time, registered result plus zero/carry/overflow/negative.
// Latency: 1 cycle for single-cycle opcodes, n+1 cycles for MUL (n shift-add iterations).
// Backpressure: result held stable in HOLD until out_ready; in_ready low while busy or holding.
// Ports: clk, rst_n (async, active low); bus = n_bit_alu_seq_if.slave carrying the
//        request handshake/operands and the result handshake/flags.
module n_bit_alu_seq #(
    parameter int n = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    n_bit_alu_seq_if.slave bus
);
    localparam int LW = $clog2(n);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

    state_t         state_q;
    logic [2*n-1:0] mcand_q;
    logic [2*n-1:0] acc_q;
    logic [n-1:0]   mplier_q;
    logic [LW-1:0]  count_q;
    logic [n-1:0]   result_q;
    logic           zero_q;
    logic           carry_q;
    logic           overflow_q;
    logic           negative_q;
    logic           out_valid_q;

    logic [n-1:0]   res_d;
    logic           carry_d;
    logic           overflow_d;
    logic [n:0]     sum_d;
    logic [LW-1:0]  shamt_d;
    logic [2*n-1:0] acc_d;

    // Single-cycle datapath, evaluated straight off the live operands; it is
    // only captured on the accept edge, so later operand changes are harmless.
    always_comb begin
        res_d      = '0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        sum_d      = '0;
        shamt_d    = bus.B[LW-1:0];
        case (bus.control)
            OP_ADD: begin
                sum_d      = {1'b0, bus.A} + {1'b0, bus.B};
                res_d      = sum_d[n-1:0];
                carry_d    = sum_d[n];
                overflow_d = (bus.A[n-1] == bus.B[n-1]) && (res_d[n-1] != bus.A[n-1]);
            end
            OP_SUB: begin
                res_d      = bus.A - bus.B;
                carry_d    = (bus.A >= bus.B);
                overflow_d = (bus.A[n-1] != bus.B[n-1]) && (res_d[n-1] != bus.A[n-1]);
            end
            OP_AND:  res_d = bus.A & bus.B;
            OP_OR:   res_d = bus.A | bus.B;
            OP_XOR:  res_d = bus.A ^ bus.B;
            OP_NOR:  res_d = ~(bus.A | bus.B);
            OP_SLL:  res_d = bus.A << shamt_d;
            OP_SRL:  res_d = bus.A >> shamt_d;
            OP_SRA:  res_d = $unsigned($signed(bus.A) >>> shamt_d);
            OP_SLT:  res_d = {{(n-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_SLTU: res_d = {{(n-1){1'b0}}, (bus.A < bus.B)};
            default: res_d = '0;  // illegal opcodes (and MUL, which takes the iterative path)
        endcase
    end

    // One shift-add step; the full 2n-bit accumulator keeps the high product
    // bits so the MUL carry (unsigned overflow) falls out directly.
    assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            acc_q       <= '0;
            mplier_q    <= '0;
            count_q     <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            negative_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.control == OP_MUL) begin
                            mcand_q  <= {{n{1'b0}}, bus.A};
                            mplier_q <= bus.B;
                            count_q  <= '0;
                            acc_q    <= '0;
                            state_q  <= S_MUL;
                        end else begin
                            result_q    <= res_d;
                            zero_q      <= (res_d == '0);
                            carry_q     <= carry_d;
                            overflow_q  <= overflow_d;
                            negative_q  <= res_d[n-1];
                            out_valid_q <= 1'b1;
                            state_q     <= S_HOLD;
                        end
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + 1'b1;
                    // Last of the n iterations: publish the product this edge.
                    if (count_q == LW'(n - 1)) begin
                        result_q    <= acc_d[n-1:0];
                        zero_q      <= (acc_d[n-1:0] == '0);
                        carry_q     <= |acc_d[2*n-1:n];
                        overflow_q  <= 1'b0;
                        negative_q  <= acc_d[n-1];
                        out_valid_q <= 1'b1;
                        state_q     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Gated by rst_n so the issue stage sees "not ready" for the whole reset window
    // and "ready" as soon as reset lets go.
    assign bus.in_ready   = rst_n && (state_q == S_IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.ALU_Result = result_q;
    assign bus.zero       = zero_q;
    assign bus.carry      = carry_q;
    assign bus.overflow   = overflow_q;
    assign bus.negative   = negative_q;
endmodule

// File: tb/tb_n_bit_alu_seq.sv
// Self-checking bench for n_bit_alu_seq (n=32): directed cases, backpressure,
// mid-multiply reset, then randomized operations against a plain-arithmetic model.
module tb_n_bit_alu_seq;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    n_bit_alu_seq_if #(.n(N)) bus ();

    n_bit_alu_seq #(.n(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
        logic        neg;
    } exp_t;

    // Reference model: ordinary 64-bit integer arithmetic on the operands.
    function automatic exp_t model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        exp_t                 e;
        longint               sa = longint'($signed(a));
        longint               sb = longint'($signed(b));
        longint unsigned      ua = 64'(a);
        longint unsigned      ub = 64'(b);
        longint unsigned      p;
        longint               s;
        logic signed [31:0]   t;
        int                   sh = int'(b % 32);
        e.res = '0; e.c = 1'b0; e.v = 1'b0;
        case (op)
            4'd0: begin
                e.res = 32'(ua + ub);
                e.c   = (ua + ub) >= 64'h1_0000_0000;
                s = sa + sb; t = 32'(s); e.v = (longint'(t) != s);
            end
            4'd1: begin
                e.res = 32'(ua - ub);
                e.c   = (ua >= ub);
                s = sa - sb; t = 32'(s); e.v = (longint'(t) != s);
            end
            4'd2:  e.res = a & b;
            4'd3:  e.res = a | b;
            4'd4:  e.res = a ^ b;
            4'd5:  e.res = ~(a | b);
            4'd6:  e.res = 32'(ua << sh);
            4'd7:  e.res = 32'(ua >> sh);
            4'd8:  e.res = 32'(sa >>> sh);
            4'd9:  e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd10: e.res = (ua < ub) ? 32'd1 : 32'd0;
            4'd11: begin
                p     = ua * ub;
                e.res = 32'(p);
                e.c   = (p >> 32) != 0;
            end
            default: e.res = '0;
        endcase
        e.z   = (e.res == 0);
        e.neg = e.res[31];
        return e;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(string tag, exp_t e);
        check({tag, "/res"}, 64'(bus.ALU_Result), 64'(e.res));
        check({tag, "/zero"}, 64'(bus.zero), 64'(e.z));
        check({tag, "/carry"}, 64'(bus.carry), 64'(e.c));
        check({tag, "/ovf"}, 64'(bus.overflow), 64'(e.v));
        check({tag, "/neg"}, 64'(bus.negative), 64'(e.neg));
    endtask

    // Drive a request at a falling edge; it must be taken on the next rising edge.
    // Afterwards the operands are scrambled to show they are not resampled.
    task automatic issue(string tag, logic [3:0] op, logic [31:0] a, logic [31:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.control  = op;
        bus.A        = a;
        bus.B        = b;
        check({tag, "/in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.control  = 4'($urandom);
        bus.A        = $urandom;
        bus.B        = $urandom;
    endtask

    // Called just after the accept edge; latency counts that edge as cycle 1.
    task automatic wait_result(string tag, exp_t e, int exp_lat);
        int lat;
        @(negedge clk);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
        check_result(tag, e);
        check({tag, "/busy"}, 64'(bus.in_ready), 64'd0);
    endtask

    // Result retires on the next rising edge (out_ready assumed high).
    task automatic retire(string tag);
        @(negedge clk);
        check({tag, "/retired"}, 64'(bus.out_valid), 64'd0);
        check({tag, "/ready_back"}, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic run(string tag, logic [3:0] op, logic [31:0] a, logic [31:0] b);
        issue(tag, op, a, b);
        wait_result(tag, model(op, a, b), (op == 4'd11) ? N + 1 : 1);
        retire(tag);
    endtask

    initial begin
        exp_t        e1;
        exp_t        e2;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.A         = '0;
        bus.B         = '0;
        bus.control   = '0;

        // Reset state.
        #1;
        check("rst/in_ready", 64'(bus.in_ready), 64'd0);
        check("rst/out_valid", 64'(bus.out_valid), 64'd0);
        check("rst/res", 64'(bus.ALU_Result), 64'd0);
        check("rst/flags", 64'({bus.zero, bus.carry, bus.overflow, bus.negative}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel/in_ready", 64'(bus.in_ready), 64'd1);
        check("rel/out_valid", 64'(bus.out_valid), 64'd0);

        // Directed cases.
        run("add15_12", 4'b0000, 32'd15, 32'd12);
        run("sub15_12", 4'b0001, 32'd15, 32'd12);
        run("sub12_15", 4'b0001, 32'd12, 32'd15);
        run("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'd1);
        run("mul_small", 4'b1011, 32'd230005, 32'd5);
        run("mul_wrap", 4'b1011, 32'h0001_0000, 32'h0001_0000);
        run("sra", 4'b1000, 32'h8000_0000, 32'd36);
        run("srl", 4'b0111, 32'h8000_0000, 32'd36);
        run("slt", 4'b1001, 32'hFFFF_FFFF, 32'd1);
        run("sltu", 4'b1010, 32'hFFFF_FFFF, 32'd1);
        run("illegal", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
        run("add_carry", 4'b0000, 32'hFFFF_FFFF, 32'd1);
        run("sub_ovf", 4'b0001, 32'h8000_0000, 32'd1);

        // Absolute expectations for the test-plan headline values.
        e1 = model(4'b1011, 32'd230005, 32'd5);
        check("model/mul_val", 64'(e1.res), 64'd1150025);

        // Backpressure: hold a result for 10 cycles with a new request pending.
        bus.out_ready = 1'b0;
        e1 = model(4'b0100, 32'hF0F0_1234, 32'h0FF0_4321);
        e2 = model(4'b0000, 32'd100, 32'd23);
        issue("bp1", 4'b0100, 32'hF0F0_1234, 32'h0FF0_4321);
        wait_result("bp1", e1, 1);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.control  = 4'b0000;
            bus.A        = 32'd100;
            bus.B        = 32'd23;
            @(negedge clk);
            check("bp/hold_valid", 64'(bus.out_valid), 64'd1);
            check("bp/hold_ready", 64'(bus.in_ready), 64'd0);
            check_result("bp/hold", e1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp/retired", 64'(bus.out_valid), 64'd0);
        check("bp/ready_back", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_result("bp2", e2, 1);
        retire("bp2");

        // Asynchronous reset in the middle of a multiply.
        issue("rstmul", 4'b1011, 32'hDEAD_BEEF, 32'h1357_9BDF);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmul/in_ready", 64'(bus.in_ready), 64'd0);
        check("rstmul/out_valid", 64'(bus.out_valid), 64'd0);
        check("rstmul/res", 64'(bus.ALU_Result), 64'd0);
        check("rstmul/flags", 64'({bus.zero, bus.carry, bus.overflow, bus.negative}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rstmul/rel_ready", 64'(bus.in_ready), 64'd1);
        run("post_rst_add", 4'b0000, 32'd2, 32'd2);

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 4 == 1) ra = 32'($urandom_range(0, 255));
            if (i % 4 == 2) rb = 32'($urandom_range(0, 63));
            run("rand", rop, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/n_bit_alu_seq.md
# n_bit_alu_seq

Parametrised, clocked successor to the combinational `n_bit_alu_four`. It accepts one operation at a time through a valid/ready handshake and registers the result together with a four-flag status word. It adds an iterative shift-add multiply that takes n cycles. The block sits between the operand/control issue stage and the writeback stage, and it holds its result under downstream backpressure.

## Interface
- `n`, 32: operand/result width; power of two, ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands and control are valid.
- `in_ready`  out  1  block can accept an operation.
- `A`  in  n  operand A.
- `B`  in  n  operand B.
- `control`  in  4  opcode.
- `out_valid`  out  1  result and flags are valid.
- `out_ready`  in  1  downstream accepts the result.
- `ALU_Result`  out  n  registered result.
- `zero`  out  1  ALU_Result == 0.
- `carry`  out  1  carry / no-borrow / unsigned multiply overflow.
- `overflow`  out  1  signed overflow.
- `negative`  out  1  ALU_Result[n-1].

## Operation
- Opcodes:
  - 0000 ADD, 0001 SUB (A−B), 0010 AND, 0011 OR, 0100 XOR, 0101 NOR.
  - 0110 SLL, 0111 SRL, 1000 SRA. The shift amount is B[log2(n)-1:0]; upper bits of B are ignored.
  - 1001 SLT (signed A<B → 1, else 0), 1010 SLTU (unsigned), 1011 MUL (low n bits of the unsigned A×B).
  - 1100–1111 are illegal: result 0, zero=1, all other flags 0, single-cycle timing.
- FSM states:
  - IDLE: in_ready=1. On in_valid at an edge, the operation is accepted. For a non-MUL opcode, the result and flags are registered and the FSM goes to HOLD. For MUL, the multiplicand, multiplier and count=0 are loaded, the accumulator is cleared, and the FSM goes to MUL.
  - MUL: each edge, if multiplier[0] is set, add the multiplicand into the accumulator. Then shift the multiplicand left and the multiplier right, and increment count. On the edge where count reaches n−1 (the n-th iteration), register the result and flags and go to HOLD.
  - HOLD: out_valid=1. Result and flags stay stable. When out_valid && out_ready at an edge, go to IDLE.
- Busy behaviour: in_ready=0 in MUL and HOLD. in_valid in those states is ignored; upstream holds its request.
- Flags:
  - zero: set for every opcode when the result is 0.
  - carry:
    - ADD: the n-th carry-out.
    - SUB: 1 when A ≥ B unsigned (no borrow).
    - MUL: 1 when any bit of the 2n-bit product above n−1 is set. The accumulator is n+n bits wide, or an equivalent sticky bit is kept.
    - All other opcodes: 0.
  - overflow: two's-complement overflow for ADD and SUB; 0 for all other opcodes.
  - negative: ALU_Result[n-1] for all opcodes.
- Arithmetic is modulo 2^n, so results wrap.
- The count register is $clog2(n) bits.

## Timing
- Reset (asynchronous, any state, including mid-MUL):
  - FSM goes to IDLE.
  - in_ready=1 while rst_n is high after release; in_ready=0 while rst_n is low.
  - out_valid=0, ALU_Result=0, and all flags 0. zero is reset to 0 and becomes meaningful only with out_valid.
  - Any partial multiply is discarded.
- Non-MUL latency: out_valid rises in the cycle immediately after the accept edge (1 cycle).
- MUL latency: out_valid rises n+1 cycles after the accept edge (n iterations).
- Throughput: at most one operation per 2 cycles for non-MUL opcodes with out_ready held high, because IDLE→HOLD→IDLE.
- out_valid falls in the cycle after the out_valid && out_ready edge. in_ready rises in that same cycle.
- Operands are sampled only at the accept edge. Changes to A, B or control afterwards do not affect an operation in flight.
- out_ready low in HOLD: hold indefinitely, with no changes to outputs.

## Test plan
- n=32, A=15, B=12, ADD → ALU_Result=27, carry=0, overflow=0, 1-cycle latency. Then SUB → 3, carry=1, negative=0.
- A=12, B=15, SUB → 0xFFFFFFFD, negative=1, carry=0. A=0x7FFFFFFF, B=1, ADD → 0x80000000, overflow=1, negative=1.
- A=230005, B=5, MUL → 1150025, carry=0, out_valid exactly 33 cycles after accept. A=0x10000, B=0x10000, MUL → 0, zero=1, carry=1.
- Shifts/compares: A=0x80000000, B=36 (amount 4), SRA → 0xF8000000 and SRL → 0x08000000. A=−1, B=1: SLT → 1, SLTU → 0. Illegal opcode 1111 → 0, zero=1.
- Backpressure: out_ready=0 for 10 cycles after a result. Outputs stay stable and in_ready=0 while in_valid is asserted with new operands. Release out_ready: the result retires, and the new operation is accepted only after in_ready returns.
- Reset asserted 10 cycles into a MUL, mid-cycle: all outputs go to 0 immediately. After release, ADD 2+2 → 4 with normal 1-cycle latency.
